// File: rtl/vec_mul_ctrl_pkg.sv
// Shared definitions for the vector-multiply sequencer: state encoding and
// default job geometry.
package vec_mul_ctrl_pkg;

  // Default number of UB vectors streamed per job.
  localparam int VM_NUM_VECTORS = 8;

  // Default cycles from UB address issue to result valid at the result SRAM.
  localparam int VM_PIPE_LAT = 9;

  // Sequencer states.
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_W = 3'd1,
    RELOAD = 3'd2,
    STREAM = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5
  } vm_state_e;

endpackage : vec_mul_ctrl_pkg

// File: rtl/valid_delay_line.sv
// Fixed-depth 1-bit shift register.
// It turns the UB read strobe into the result-SRAM write strobe by delaying
// it exactly PIPE_LAT cycles. An async clear discards any in-flight strobes.
module valid_delay_line
  import vec_mul_ctrl_pkg::*;
#(
  parameter int PIPE_LAT = VM_PIPE_LAT
) (
  input  logic clk,
  input  logic rstn,
  input  logic valid_i,
  output logic valid_o
);

  logic [PIPE_LAT-1:0] sr_q;
  logic [PIPE_LAT-1:0] sr_d;

  // Shift toward the MSB. The new strobe enters at bit 0.
  // The shift-then-insert form also covers PIPE_LAT == 1.
  always_comb begin
    sr_d    = sr_q << 1;
    sr_d[0] = valid_i;
  end

  // Shift register state; cleared asynchronously so pending writes are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign valid_o = sr_q[PIPE_LAT-1];

endmodule : valid_delay_line

// File: rtl/vec_mul_controller.sv
// Sequencer for the 1x64 vector-multiply datapath.
// One job runs in this order:
//   - pop a weight set from the weight FIFO;
//   - strobe a weight reload into the array;
//   - stream NUM_VECTORS consecutive UB addresses;
//   - write each result row PIPE_LAT cycles after its address was issued;
//   - pulse end_ once the last write has gone out.
//
// Handshake semantics:
//   - start is a level that is only sampled in IDLE. It is ignored, not
//     queued, in every other state.
//   - The FIFO pop (fifo_read_enable) is issued only in LOAD_W while
//     fifo_empty is low. An empty FIFO stalls the job indefinitely.
//   - ub_addr and res_address are qualified by ub_addr_valid and
//     res_write_enable respectively, and they read as zero when not qualified.
module vec_mul_controller
  import vec_mul_ctrl_pkg::*;
#(
  parameter int ADDRESSSIZE = 10,
  parameter int NUM_VECTORS = VM_NUM_VECTORS,
  parameter int PIPE_LAT    = VM_PIPE_LAT
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   start,
  input  logic [ADDRESSSIZE-1:0] ub_base_addr,
  input  logic [ADDRESSSIZE-1:0] res_base_addr,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enable,
  output logic                   weight_reload,
  output logic [ADDRESSSIZE-1:0] ub_addr,
  output logic                   ub_addr_valid,
  output logic                   res_write_enable,
  output logic [ADDRESSSIZE-1:0] res_address,
  output logic                   busy,
  output logic                   end_
);

  localparam int            CW     = $clog2(NUM_VECTORS + 1);
  localparam logic [CW-1:0] LAST_I = CW'(NUM_VECTORS - 1);
  localparam logic [CW-1:0] NUM_V  = CW'(NUM_VECTORS);

  vm_state_e              state_q, state_d;
  logic [ADDRESSSIZE-1:0] ub_base_q, ub_base_d;
  logic [ADDRESSSIZE-1:0] res_base_q, res_base_d;
  logic [CW-1:0]          i_q, i_d;   // UB addresses issued in this job
  logic [CW-1:0]          j_q, j_d;   // result writes completed in this job
  logic                   wr_strobe;

  // Delays the UB read strobe by the datapath latency to form the write strobe.
  valid_delay_line #(
    .PIPE_LAT(PIPE_LAT)
  ) u_valid_delay_line (
    .clk    (clk),
    .rstn   (rstn),
    .valid_i(ub_addr_valid),
    .valid_o(wr_strobe)
  );

  // Next-state, base-address latch and issue/write counter updates.
  always_comb begin
    state_d    = state_q;
    ub_base_d  = ub_base_q;
    res_base_d = res_base_q;
    i_d        = i_q;
    j_d        = j_q;

    // Writes retire in any state; DRAIN looks at the post-increment count
    // so end_ lands in the cycle right after the final write.
    if (wr_strobe) j_d = j_q + CW'(1);

    case (state_q)
      IDLE: begin
        if (start) begin
          ub_base_d  = ub_base_addr;
          res_base_d = res_base_addr;
          i_d        = '0;
          j_d        = '0;
          state_d    = LOAD_W;
        end
      end
      LOAD_W: begin
        if (!fifo_empty) state_d = RELOAD;
      end
      RELOAD: begin
        state_d = STREAM;
      end
      STREAM: begin
        i_d = i_q + CW'(1);
        if (i_q == LAST_I) state_d = DRAIN;
      end
      DRAIN: begin
        if (j_d == NUM_V) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, base-address and counter registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= IDLE;
      ub_base_q  <= '0;
      res_base_q <= '0;
      i_q        <= '0;
      j_q        <= '0;
    end else begin
      state_q    <= state_d;
      ub_base_q  <= ub_base_d;
      res_base_q <= res_base_d;
      i_q        <= i_d;
      j_q        <= j_d;
    end
  end

  // Output decode from registered state and counters.
  // Address sums wrap modulo 2^ADDRESSSIZE.
  assign fifo_read_enable = (state_q == LOAD_W) && !fifo_empty;
  assign weight_reload    = (state_q == RELOAD);
  assign ub_addr_valid    = (state_q == STREAM);
  assign ub_addr          = ub_addr_valid ? ub_base_q + ADDRESSSIZE'(i_q) : '0;
  assign res_write_enable = wr_strobe;
  assign res_address      = wr_strobe ? res_base_q + ADDRESSSIZE'(j_q) : '0;
  assign busy             = (state_q != IDLE);
  assign end_             = (state_q == DONE);

endmodule : vec_mul_controller

// File: tb/tb_vec_mul_controller.sv
// Directed bench for vec_mul_controller.
// Cycle c is the interval between edge c-1 and edge c, where start is
// sampled at edge 0. Inputs change 1 time unit after a rising edge, and
// outputs are sampled on the falling edge.
module tb_vec_mul_controller;

  localparam int AW = 10;

  logic          clk;
  logic          rstn;

  // Default-geometry instance (8 vectors, latency 9).
  logic          start;
  logic [AW-1:0] ub_base;
  logic [AW-1:0] res_base;
  logic          fifo_empty;
  logic          pop;
  logic          reload;
  logic [AW-1:0] ua;
  logic          uav;
  logic          we;
  logic [AW-1:0] ra;
  logic          busy;
  logic          done;

  // Minimal-geometry instance (1 vector, latency 1).
  logic          start2;
  logic [AW-1:0] ub_base2;
  logic [AW-1:0] res_base2;
  logic          fifo_empty2;
  logic          pop2;
  logic          reload2;
  logic [AW-1:0] ua2;
  logic          uav2;
  logic          we2;
  logic [AW-1:0] ra2;
  logic          busy2;
  logic          done2;

  int n_cmp;
  int n_bad;

  vec_mul_controller #(
    .ADDRESSSIZE(AW),
    .NUM_VECTORS(8),
    .PIPE_LAT   (9)
  ) dut (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start),
    .ub_base_addr    (ub_base),
    .res_base_addr   (res_base),
    .fifo_empty      (fifo_empty),
    .fifo_read_enable(pop),
    .weight_reload   (reload),
    .ub_addr         (ua),
    .ub_addr_valid   (uav),
    .res_write_enable(we),
    .res_address     (ra),
    .busy            (busy),
    .end_            (done)
  );

  vec_mul_controller #(
    .ADDRESSSIZE(AW),
    .NUM_VECTORS(1),
    .PIPE_LAT   (1)
  ) dut_small (
    .clk             (clk),
    .rstn            (rstn),
    .start           (start2),
    .ub_base_addr    (ub_base2),
    .res_base_addr   (res_base2),
    .fifo_empty      (fifo_empty2),
    .fifo_read_enable(pop2),
    .weight_reload   (reload2),
    .ub_addr         (ua2),
    .ub_addr_valid   (uav2),
    .res_write_enable(we2),
    .res_address     (ra2),
    .busy            (busy2),
    .end_            (done2)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Packed observation word: {pop, reload, uav, ua, we, ra, busy, end_}.
  function automatic logic [25:0] obs();
    return {pop, reload, uav, ua, we, ra, busy, done};
  endfunction

  function automatic logic [25:0] obs2();
    return {pop2, reload2, uav2, ua2, we2, ra2, busy2, done2};
  endfunction

  // Expected observation for cycle c of a job.
  //   s   = cycles stalled in LOAD_W;
  //   ub  = UB base address;
  //   rs  = result base address;
  //   n   = vectors per job;
  //   p   = pipeline latency.
  function automatic logic [25:0] exp_at(input int c, input int s,
                                         input logic [AW-1:0] ub,
                                         input logic [AW-1:0] rs,
                                         input int n, input int p);
    int            t;
    logic          e_pop, e_rel, e_v, e_we, e_busy, e_end;
    logic [AW-1:0] e_ua, e_ra;
    t      = c - s;
    e_pop  = (c == 1 + s);
    e_rel  = (t == 2);
    e_v    = (t >= 3) && (t <= 2 + n);
    e_ua   = e_v ? ub + AW'(t - 3) : '0;
    e_we   = (t >= 3 + p) && (t <= 2 + p + n);
    e_ra   = e_we ? rs + AW'(t - 3 - p) : '0;
    e_end  = (t == 3 + p + n);
    e_busy = (c >= 1) && (t <= 3 + p + n);
    return {e_pop, e_rel, e_v, e_ua, e_we, e_ra, e_busy, e_end};
  endfunction

  // ---------------- driver tasks ----------------
  // Present start for one edge (edge 0) with the given bases.
  task automatic launch(input logic [AW-1:0] ub, input logic [AW-1:0] rs);
    @(posedge clk);
    #1;
    ub_base  = ub;
    res_base = rs;
    start    = 1'b1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    logic [25:0] got;
    rstn        = 1'b0;
    start       = 1'b0;
    ub_base     = '0;
    res_base    = '0;
    fifo_empty  = 1'b0;
    start2      = 1'b0;
    ub_base2    = '0;
    res_base2   = '0;
    fifo_empty2 = 1'b0;
    repeat (3) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_in: got %h want %h", got, 26'h0);
    end
    got = obs2();
    n_cmp++;
    if (got !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_in_small: got %h want %h", got, 26'h0);
    end
    rstn = 1'b1;
    repeat (2) @(negedge clk);
    got = obs();
    n_cmp++;
    if (got !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_out: got %h want %h", got, 26'h0);
    end
  endtask

  task automatic test_nominal();
    logic [25:0] got, want;
    fifo_empty = 1'b0;
    launch(10'h010, 10'h200);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 0, 10'h010, 10'h200, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL nominal cycle %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_fifo_stall();
    logic [25:0] got, want;
    fifo_empty = 1'b1;
    launch(10'h040, 10'h100);
    for (int c = 1; c <= 27; c++) begin
      @(posedge clk);
      #1;
      start      = 1'b0;
      fifo_empty = (c <= 5);
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 5, 10'h040, 10'h100, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL fifo_stall cycle %0d: got %h want %h", c, got, want);
      end
    end
    fifo_empty = 1'b0;
  endtask

  task automatic test_wrap();
    logic [25:0] got, want;
    fifo_empty = 1'b0;
    launch(10'h3FE, 10'h3FC);
    for (int c = 1; c <= 22; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 0, 10'h3FE, 10'h3FC, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL wrap cycle %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [25:0] got, want;
    fifo_empty = 1'b0;
    launch(10'h080, 10'h300);
    // start is held through cycle 5, re-pulsed in cycles 12 and 20 (DONE),
    // then raised in cycle 21, the first IDLE cycle after end_.
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      #1 start = (c <= 5) || (c == 12) || (c == 20) || (c == 21);
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 0, 10'h080, 10'h300, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b_first cycle %0d: got %h want %h", c, got, want);
      end
    end
    for (int c = 1; c <= 21; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 0, 10'h080, 10'h300, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL b2b_second cycle %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  task automatic test_reset_mid_stream();
    logic [25:0] got, want;
    fifo_empty = 1'b0;
    launch(10'h020, 10'h220);
    for (int c = 1; c <= 8; c++) begin
      @(posedge clk);
      #1 start = 1'b0;
      @(negedge clk);
      got  = obs();
      want = exp_at(c, 0, 10'h020, 10'h220, 8, 9);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL pre_reset cycle %0d: got %h want %h", c, got, want);
      end
    end
    // Still in cycle 8, mid-STREAM: assert reset and look straight away.
    rstn = 1'b0;
    #1;
    got = obs();
    n_cmp++;
    if (got !== 26'h0) begin
      n_bad++;
      $display("FAIL reset_immediate: got %h want %h", got, 26'h0);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    for (int c = 1; c <= 25; c++) begin
      @(negedge clk);
      got = obs();
      n_cmp++;
      if (got !== 26'h0) begin
        n_bad++;
        $display("FAIL post_reset cycle %0d: got %h want %h", c, got, 26'h0);
      end
    end
  endtask

  task automatic test_min_geometry();
    logic [25:0] got, want;
    @(posedge clk);
    #1;
    ub_base2    = 10'h155;
    res_base2   = 10'h2AA;
    fifo_empty2 = 1'b0;
    start2      = 1'b1;
    for (int c = 1; c <= 7; c++) begin
      @(posedge clk);
      #1 start2 = 1'b0;
      @(negedge clk);
      got  = obs2();
      want = exp_at(c, 0, 10'h155, 10'h2AA, 1, 1);
      n_cmp++;
      if (got !== want) begin
        n_bad++;
        $display("FAIL min_geometry cycle %0d: got %h want %h", c, got, want);
      end
    end
  endtask

  // ---------------- sequence and final report ----------------
  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_nominal();
    test_fifo_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid_stream();
    test_nominal();
    test_min_geometry();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vec_mul_controller
